// File: rtl/seq_shift_left8_if.sv
// Handshake bundle for the multi-cycle left shifter: request channel in, result channel out.
// The producer/consumer side uses master and the shifter uses slave.
interface seq_shift_left8_if #(
  parameter int WIDTH = 8,
  parameter int AMT_W = 3
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_data;
  logic [AMT_W-1:0] in_amt;
  logic             in_rot;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_data;
  logic             out_carry;

  modport master (
    output in_valid,
    input  in_ready,
    output in_data,
    output in_amt,
    output in_rot,
    input  out_valid,
    output out_ready,
    input  out_data,
    input  out_carry
  );

  modport slave (
    input  in_valid,
    output in_ready,
    input  in_data,
    input  in_amt,
    input  in_rot,
    output out_valid,
    input  out_ready,
    output out_data,
    output out_carry
  );
endinterface

// File: rtl/seq_shift_left8.sv
// Multi-cycle left shifter/rotator: one bit position per clock, valid/ready on both sides.
// The working register doubles as the result register, so out_data is registered.
module seq_shift_left8 #(
  parameter int WIDTH = 8,
  parameter int AMT_W = 3
) (
  input logic          clk,
  input logic          rst,
  seq_shift_left8_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t           state_r;
  state_t           state_nxt_s;
  logic [WIDTH-1:0] data_r;
  logic [WIDTH-1:0] data_nxt_s;
  logic [AMT_W-1:0] cnt_r;
  logic [AMT_W-1:0] cnt_nxt_s;
  logic             rot_r;
  logic             rot_nxt_s;
  logic             carry_r;
  logic             carry_nxt_s;
  logic             fill_s;
  logic             in_ready_r;
  logic             out_valid_r;

  // Next-state and datapath update for the IDLE/SHIFT/DONE sequence.
  always_comb begin
    state_nxt_s = state_r;
    data_nxt_s  = data_r;
    cnt_nxt_s   = cnt_r;
    rot_nxt_s   = rot_r;
    carry_nxt_s = carry_r;
    fill_s      = 1'b0;
    case (state_r)
      IDLE: begin
        if (bus.in_valid && in_ready_r) begin
          data_nxt_s  = bus.in_data;
          cnt_nxt_s   = bus.in_amt;
          rot_nxt_s   = bus.in_rot;
          carry_nxt_s = 1'b0;
          if (bus.in_amt == {AMT_W{1'b0}}) begin
            state_nxt_s = DONE;
          end else begin
            state_nxt_s = SHIFT;
          end
        end else begin
          state_nxt_s = IDLE;
        end
      end
      SHIFT: begin
        // Rotate feeds the exiting MSB back in; logical shift feeds zero.
        if (rot_r) begin
          fill_s = data_r[WIDTH-1];
        end else begin
          fill_s = 1'b0;
        end
        carry_nxt_s = data_r[WIDTH-1];
        data_nxt_s  = {data_r[WIDTH-2:0], fill_s};
        cnt_nxt_s   = cnt_r - AMT_W'(1);
        if (cnt_r == AMT_W'(1)) begin
          state_nxt_s = DONE;
        end else begin
          state_nxt_s = SHIFT;
        end
      end
      DONE: begin
        if (out_valid_r && bus.out_ready) begin
          state_nxt_s = IDLE;
        end else begin
          state_nxt_s = DONE;
        end
      end
      default: begin
        state_nxt_s = IDLE;
      end
    endcase
  end

  // State, datapath and handshake-flag registers; flags are decoded from the next state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r     <= IDLE;
      data_r      <= {WIDTH{1'b0}};
      cnt_r       <= {AMT_W{1'b0}};
      rot_r       <= 1'b0;
      carry_r     <= 1'b0;
      in_ready_r  <= 1'b1;
      out_valid_r <= 1'b0;
    end else begin
      state_r     <= state_nxt_s;
      data_r      <= data_nxt_s;
      cnt_r       <= cnt_nxt_s;
      rot_r       <= rot_nxt_s;
      carry_r     <= carry_nxt_s;
      in_ready_r  <= (state_nxt_s == IDLE);
      out_valid_r <= (state_nxt_s == DONE);
    end
  end

  assign bus.in_ready  = in_ready_r;
  assign bus.out_valid = out_valid_r;
  assign bus.out_data  = data_r;
  assign bus.out_carry = carry_r;

endmodule

// File: tb/tb_seq_shift_left8.sv
// Scoreboard bench for seq_shift_left8: the driver queues hand-computed results at accept time,
// a monitor branch pops and compares on every output handshake and checks first-valid latency.
module tb_seq_shift_left8;

  typedef struct {
    string      tag;
    logic [7:0] data;
    logic       carry;
    int         rise;
  } exp_t;

  logic clk;
  logic rst;
  int   cyc;
  int   total;
  int   bad;
  logic prev_valid;
  exp_t sb[$];

  seq_shift_left8_if #(.WIDTH(8), .AMT_W(3)) bus ();

  seq_shift_left8 #(.WIDTH(8), .AMT_W(3)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic fail(input string name);
    total++;
    bad++;
    $display("FAIL %s: event did not occur as required (cycle %0d)", name, cyc);
  endtask

  // Drives one request; the expected result is queued on the negedge before the accept edge.
  task automatic send(input string tag, input logic [7:0] d, input logic [2:0] a, input logic r,
                      input logic [7:0] ed, input logic ec);
    exp_t e;
    bit   took;
    @(posedge clk);
    #1;
    bus.in_valid = 1'b1;
    bus.in_data  = d;
    bus.in_amt   = a;
    bus.in_rot   = r;
    took = 1'b0;
    for (int i = 0; i < 40 && !took; i++) begin
      @(negedge clk);
      if (bus.in_ready) begin
        e.tag   = tag;
        e.data  = ed;
        e.carry = ec;
        e.rise  = cyc + int'(a) + 1;
        sb.push_back(e);
        took = 1'b1;
      end
    end
    if (!took) fail({tag, "_accept_timeout"});
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
  endtask

  task automatic drain();
    for (int i = 0; i < 40 && sb.size() != 0; i++) @(negedge clk);
    if (sb.size() != 0) fail("drain_timeout");
    @(negedge clk);
  endtask

  initial begin
    exp_t e;
    int   hs_cyc;
    bit   seen;
    cyc            = 0;
    total          = 0;
    bad            = 0;
    prev_valid     = 1'b0;
    rst            = 1'b1;
    bus.in_valid   = 1'b0;
    bus.in_data    = 8'h00;
    bus.in_amt     = 3'd0;
    bus.in_rot     = 1'b0;
    bus.out_ready  = 1'b1;

    fork
      forever begin
        @(negedge clk);
        if (bus.out_valid && !prev_valid) begin
          if (sb.size() == 0) fail("unexpected_out_valid");
          else check({sb[0].tag, "_latency"}, cyc, sb[0].rise);
        end
        if (bus.out_valid && bus.out_ready) begin
          if (sb.size() == 0) begin
            fail("unexpected_result");
          end else begin
            e = sb.pop_front();
            check({e.tag, "_data"}, {24'd0, bus.out_data}, {24'd0, e.data});
            check({e.tag, "_carry"}, {31'd0, bus.out_carry}, {31'd0, e.carry});
          end
        end
        prev_valid = bus.out_valid;
      end
    join_none

    // Reset state
    repeat (2) @(negedge clk);
    check("rst_in_ready", {31'd0, bus.in_ready}, 32'd1);
    check("rst_out_valid", {31'd0, bus.out_valid}, 32'd0);
    check("rst_out_data", {24'd0, bus.out_data}, 32'h0);
    check("rst_out_carry", {31'd0, bus.out_carry}, 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;

    // Main function and amount boundaries
    send("lsl_b3_3", 8'hB3, 3'd3, 1'b0, 8'h98, 1'b1);  drain();
    send("rol_b3_3", 8'hB3, 3'd3, 1'b1, 8'h9D, 1'b1);  drain();
    send("lsl_5a_0", 8'h5A, 3'd0, 1'b0, 8'h5A, 1'b0);  drain();
    send("rol_5a_0", 8'h5A, 3'd0, 1'b1, 8'h5A, 1'b0);  drain();
    send("lsl_01_7", 8'h01, 3'd7, 1'b0, 8'h80, 1'b0);  drain();
    send("lsl_ff_7", 8'hFF, 3'd7, 1'b0, 8'h80, 1'b1);  drain();
    send("rol_81_7", 8'h81, 3'd7, 1'b1, 8'hC0, 1'b0);  drain();
    send("lsl_80_1", 8'h80, 3'd1, 1'b0, 8'h00, 1'b1);  drain();

    // Backpressure with a second request held on the input
    bus.out_ready = 1'b0;
    send("bp_first", 8'hB3, 3'd3, 1'b0, 8'h98, 1'b1);
    bus.in_valid = 1'b1;
    bus.in_data  = 8'h0F;
    bus.in_amt   = 3'd4;
    bus.in_rot   = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(negedge clk);
      check("bp_in_ready_busy", {31'd0, bus.in_ready}, 32'd0);
      if (bus.out_valid) seen = 1'b1;
    end
    if (!seen) fail("bp_out_valid_timeout");
    for (int k = 0; k < 5; k++) begin
      check("bp_hold_valid", {31'd0, bus.out_valid}, 32'd1);
      check("bp_hold_data", {24'd0, bus.out_data}, 32'h98);
      check("bp_hold_carry", {31'd0, bus.out_carry}, 32'd1);
      check("bp_hold_in_ready", {31'd0, bus.in_ready}, 32'd0);
      @(negedge clk);
    end
    @(posedge clk);
    #1;
    bus.out_ready = 1'b1;
    @(negedge clk);
    hs_cyc = cyc;
    check("bp_in_ready_at_hs", {31'd0, bus.in_ready}, 32'd0);
    @(negedge clk);
    check("bp_second_accept_cycle", cyc, hs_cyc + 1);
    check("bp_in_ready_after_hs", {31'd0, bus.in_ready}, 32'd1);
    e.tag   = "bp_second";
    e.data  = 8'hF0;
    e.carry = 1'b0;
    e.rise  = cyc + 5;
    sb.push_back(e);
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    drain();

    // Reset two cycles into a six-step shift
    send("rst_abort", 8'h3C, 3'd6, 1'b0, 8'h00, 1'b0);
    @(posedge clk);
    @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    sb.delete();
    check("abort_out_valid", {31'd0, bus.out_valid}, 32'd0);
    check("abort_out_data", {24'd0, bus.out_data}, 32'h0);
    check("abort_out_carry", {31'd0, bus.out_carry}, 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    check("abort_in_ready", {31'd0, bus.in_ready}, 32'd1);
    check("abort_out_valid_after", {31'd0, bus.out_valid}, 32'd0);
    send("post_rst_0f_4", 8'h0F, 3'd4, 1'b0, 8'hF0, 1'b0);
    drain();

    check("scoreboard_empty", sb.size(), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/seq_shift_left8.md
Name: seq_shift_left8

Overview:
- Multi-cycle left shifter/rotator. It is the opposite direction to the team's combinational 8-bit right barrel shifter.
- Takes an operand and shift amount through a valid/ready handshake, shifts one bit position per clock, and returns the result through an output valid/ready handshake.
- Used in area-constrained datapaths where a full left barrel is not justified.

Parameters:
- WIDTH, 8, operand/result width in bits.
- AMT_W, 3, shift-amount width. Must equal clog2(WIDTH).

Ports:
- clk  input  1  single clock; all state updates on rising edge.
- rst  input  1  asynchronous, active-high reset.
- in_valid  input  1  request valid.
- in_ready  output  1  block can accept a request.
- in_data  input  WIDTH  operand.
- in_amt  input  AMT_W  shift amount, 0..WIDTH-1.
- in_rot  input  1  0 = logical shift left (zero fill), 1 = rotate left.
- out_valid  output  1  result valid.
- out_ready  input  1  consumer accepts result.
- out_data  output  WIDTH  shifted/rotated result.
- out_carry  output  1  last bit that left the MSB position; 0 when amt = 0.

Behaviour:
- Reset (async assert, any state): state = IDLE, in_ready = 1, out_valid = 0, out_data = 0, out_carry = 0, internal counter = 0, captured mode = 0.
- FSM states: IDLE, SHIFT, DONE.
- in_ready = 1 only in IDLE. out_valid = 1 only in DONE. There is no bypass: a new request cannot be accepted in the same cycle a result is consumed.
- IDLE:
  - On in_valid & in_ready, capture in_data into the working register, in_amt into the counter, in_rot into the mode, and clear carry.
  - Next state is DONE if in_amt == 0, otherwise SHIFT.
  - in_valid low: remain in IDLE.
- SHIFT, each clock:
  - carry <= reg[WIDTH-1].
  - reg <= {reg[WIDTH-2:0], fill}, where fill = reg[WIDTH-1] in rotate mode and 0 in logical mode.
  - counter decrements.
  - When the counter is 1 before the edge, the next state is DONE.
- DONE:
  - out_data = working register and out_carry = carry, both stable while out_valid & !out_ready.
  - On out_valid & out_ready, go to IDLE.
  - out_data and out_carry keep their last values in IDLE; consumers must not rely on them.
- Latency: if the accept handshake occurs in cycle C0, out_valid is first high in cycle C0 + in_amt + 1. So amt = 0 takes 1 cycle and amt = 7 takes 8 cycles.
- Throughput: one request per (in_amt + 2) cycles minimum, with out_ready held high.
- Inputs in_data, in_amt and in_rot are sampled only at the accept edge. Later changes have no effect on the operation in flight.
- Back-to-back requests: in_valid held high during SHIFT/DONE is ignored until IDLE is re-entered.
- Arithmetic:
  - Result equals (in_data << in_amt) truncated to WIDTH for logical mode, and rotl(in_data, in_amt) for rotate mode.
  - Logical-mode carry equals in_data[WIDTH - in_amt] for in_amt > 0.
  - Rotate-mode carry equals the same bit, because the MSB-exit order is identical.
- Reset during SHIFT or DONE aborts the operation. No output handshake occurs for it, and the block returns to IDLE with in_ready = 1 in the first cycle after reset deasserts.

Test Plan:
1. Logical shift, long amount:
   - Stimulus: in_data = 8'hB3, in_amt = 3, in_rot = 0, accepted in C0.
   - Response: out_valid first in C4; out_data = 8'h98, out_carry = 1.
2. Rotate:
   - Stimulus: in_data = 8'hB3, in_amt = 3, in_rot = 1.
   - Response: out_data = 8'h9D, out_carry = 1, out_valid in C4.
3. Zero and maximum amounts:
   - in_data = 8'h5A, in_amt = 0 -> out_data = 8'h5A, out_carry = 0, out_valid in C1.
   - in_data = 8'h01, in_amt = 7, logical -> out_data = 8'h80, out_carry = 0.
   - in_data = 8'hFF, in_amt = 7, logical -> out_data = 8'h80, out_carry = 1.
4. Backpressure:
   - Stimulus: out_ready held low 5 cycles after out_valid rises, with in_valid held high and new data applied.
   - Response: out_data and out_carry remain stable; in_ready stays 0; the second request is accepted only in the cycle after the out handshake.
5. Reset mid-operation:
   - Stimulus: assert rst asynchronously two cycles into a SHIFT with in_amt = 6.
   - Response: out_valid = 0 and out_data = 0 immediately; in_ready = 1 after release; the next request with 8'h0F, amt 4, logical gives 8'hF0, carry 0.
